// File: rtl/logic_op_arbiter.sv
// Round-robin shared bitwise logic unit: one requester is granted, its operands are
// captured, the result is registered and returned on a valid/ready response channel.
module logic_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [2:0]               rsp_op,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic [IDW:0]     cand_sum;
  logic [IDW-1:0]   cand;
  logic             accept;

  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [IDW-1:0]   id_p0;
  logic [WIDTH-1:0] result_p1;
  logic             err_p1;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    logic_op = ~a;
      3'd1:    logic_op = a & b;
      3'd2:    logic_op = a | b;
      3'd3:    logic_op = ~(a & b);
      3'd4:    logic_op = ~(a | b);
      3'd5:    logic_op = a ^ b;
      3'd6:    logic_op = ~(a ^ b);
      default: logic_op = '0;
    endcase
  endfunction

  // Round-robin search starting one past the last served requester
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ))
        cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      cand = cand_sum[IDW-1:0];
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Reset is folded in so no grant is visible while rst is asserted
  assign accept = (state == IDLE) && rst && grant_any;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // p0: operands captured on accept
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr   <= IDW'(NUM_REQ - 1);
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      id_p0 <= '0;
    end else if (accept) begin
      ptr   <= grant_id;
      op_p0 <= req_op[3*grant_id +: 3];
      a_p0  <= req_a[WIDTH*grant_id +: WIDTH];
      b_p0  <= req_b[WIDTH*grant_id +: WIDTH];
      id_p0 <= grant_id;
    end
  end

  // p1: result registered in EXEC, held through RESP
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_p1 <= '0;
      err_p1    <= 1'b0;
    end else if (state == EXEC) begin
      result_p1 <= logic_op(op_p0, a_p0, b_p0);
      err_p1    <= (op_p0 == 3'd7);
    end
  end

  assign rsp_id     = id_p0;
  assign rsp_op     = op_p0;
  assign rsp_result = result_p1;
  assign rsp_err    = err_p1;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed tables, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_logic_op_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [2:0]     rsp_op;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic_op_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_op(rsp_op), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return ~a;
      1: return a & b;
      2: return a | b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send(input int id, input int op, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_op[3*id +: 3] = 3'(op);
    req_a[W*id +: W] = a;
    req_b[W*id +: W] = b;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      if (req_ready[id]) ok = 1;
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic get_rsp(output logic [1:0] id, output logic [2:0] op,
                         output logic [7:0] res, output logic err);
    int waited;
    rsp_ready = 1'b1;
    waited = 0;
    #1;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("rsp_arrive", 32'(rsp_valid), 32'd1);
    id = rsp_id; op = rsp_op; res = rsp_result; err = rsp_err;
    @(negedge clk);
  endtask

  typedef struct {
    int         op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  initial begin
    vec_t       tbl [8];
    logic [1:0] gid;
    logic [2:0] gop;
    logic [7:0] gres;
    logic       gerr;
    int         ids [8];
    int         tstamp [8];
    int         nrsp, cyc, bad;
    int         mptr, acc_cyc, w;
    bit         outstanding;
    logic [1:0] e_id;
    logic [2:0] e_op;
    logic [7:0] e_res;
    logic       e_err;
    logic       exp_rv;
    logic [3:0] exp_rdy;

    tbl[0] = '{0, 8'hA5, 8'h0F, 8'h5A, 1'b0};
    tbl[1] = '{1, 8'hA5, 8'h0F, 8'h05, 1'b0};
    tbl[2] = '{2, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    tbl[3] = '{3, 8'hA5, 8'h0F, 8'hFA, 1'b0};
    tbl[4] = '{4, 8'hA5, 8'h0F, 8'h50, 1'b0};
    tbl[5] = '{5, 8'hA5, 8'h0F, 8'hAA, 1'b0};
    tbl[6] = '{6, 8'hA5, 8'h0F, 8'h55, 1'b0};
    tbl[7] = '{7, 8'hA5, 8'h0F, 8'h00, 1'b1};

    // T1 reset with every requester valid
    rst = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t1_req_ready_rst", 32'(req_ready), 32'h0);
    check("t1_rsp_valid_rst", 32'(rsp_valid), 32'h0);
    check("t1_busy_rst", 32'(busy), 32'h0);
    check("t1_result_rst", 32'(rsp_result), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_first_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    get_rsp(gid, gop, gres, gerr);
    check("t1_first_id", 32'(gid), 32'd0);
    check("t1_first_result", 32'(gres), 32'hFF);

    // T2 single XOR, latency and fields
    rsp_ready = 1'b1;
    send(1, 5, 8'hF0, 8'h3C);
    #1;
    check("t2_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t2_exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_rsp_id", 32'(rsp_id), 32'd1);
    check("t2_rsp_result", 32'(rsp_result), 32'hCC);
    check("t2_rsp_err", 32'(rsp_err), 32'd0);
    check("t2_rsp_op", 32'(rsp_op), 32'd5);
    @(negedge clk);
    #1;
    check("t2_back_idle_valid", 32'(rsp_valid), 32'd0);
    check("t2_back_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // T3 opcode table
    for (int i = 0; i < 8; i++) begin
      send(i % N, tbl[i].op, tbl[i].a, tbl[i].b);
      get_rsp(gid, gop, gres, gerr);
      check($sformatf("t3_result_op%0d", i), 32'(gres), 32'(tbl[i].res));
      check($sformatf("t3_err_op%0d", i), 32'(gerr), 32'(tbl[i].err));
      check($sformatf("t3_id_op%0d", i), 32'(gid), 32'(i % N));
    end

    // T4 fairness with all requesters valid
    do_reset();
    req_op = 12'h249; req_a = 32'h44332211; req_b = 32'hFFFFFFFF;
    req_valid = 4'hF; rsp_ready = 1'b1;
    nrsp = 0; cyc = 0;
    while (nrsp < 8 && cyc < 100) begin
      #1;
      if (rsp_valid) begin
        ids[nrsp] = int'(rsp_id);
        tstamp[nrsp] = cyc;
        nrsp++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    check("t4_count", 32'(nrsp), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < nrsp) begin
        check($sformatf("t4_id%0d", k), 32'(ids[k]), 32'(k % N));
        if (k > 0) check($sformatf("t4_spacing%0d", k), 32'(tstamp[k] - tstamp[k-1]), 32'd3);
      end
    end

    // T5 backpressure
    do_reset();
    send(2, 6, 8'h3C, 8'h0F);
    req_valid = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_id", 32'(rsp_id), 32'd2);
      check("t5_hold_op", 32'(rsp_op), 32'd6);
      check("t5_hold_result", 32'(rsp_result), 32'hCC);
      check("t5_hold_req_ready", 32'(req_ready), 32'h0);
      check("t5_hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t5_release_valid", 32'(rsp_valid), 32'd0);
    check("t5_release_busy", 32'(busy), 32'd0);
    check("t5_next_grant", 32'(req_ready), 32'h8);

    // T6 reset during EXEC
    do_reset();
    rsp_ready = 1'b1;
    send(1, 1, 8'hFF, 8'h0F);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp_valid || busy) bad++;
      @(negedge clk);
    end
    check("t6_no_response", 32'(bad), 32'd0);
    req_valid = 4'hF;
    #1;
    check("t6_ptr_reset_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);

    // Randomized run against the transaction-level model
    do_reset();
    mptr = N - 1; outstanding = 0; acc_cyc = 0;
    e_id = '0; e_op = '0; e_res = '0; e_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_op = 12'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rv = outstanding && (c >= acc_cyc + 2);
      w = outstanding ? -1 : winner(req_valid, mptr);
      exp_rdy = (w < 0) ? 4'h0 : 4'(1 << w);
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rnd_busy", 32'(busy), 32'(outstanding));
      if (exp_rv && rsp_ready) begin
        check("rnd_rsp_id", 32'(rsp_id), 32'(e_id));
        check("rnd_rsp_op", 32'(rsp_op), 32'(e_op));
        check("rnd_rsp_result", 32'(rsp_result), 32'(e_res));
        check("rnd_rsp_err", 32'(rsp_err), 32'(e_err));
        outstanding = 0;
      end else if (w >= 0) begin
        e_id = 2'(w);
        e_op = req_op[3*w +: 3];
        e_res = ref_op(int'(e_op), req_a[W*w +: W], req_b[W*w +: W]);
        e_err = (e_op == 3'd7);
        mptr = w;
        acc_cyc = c;
        outstanding = 1;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
